// File: rtl/rr_compactor_pkg.sv
// Shared types and width helpers for the logb compactor slice.
package rr_compactor_pkg;

  typedef enum logic [1:0] {
    ST_RUN         = 2'd0,
    ST_FLUSH_PAD   = 2'd1,
    ST_FLUSH_DRAIN = 2'd2
  } rr_cmp_state_t;

  // fill must hold values up to 2*OUT_WIDTH while a word is being cut
  function automatic int FILL_WIDTH(input int out_width);
    return $clog2(2 * out_width + 1);
  endfunction

  function automatic int LEN_WIDTH(input int in_width);
    return $clog2(in_width + 1);
  endfunction

  typedef struct packed {
    logic [63:0] bits;
    logic [31:0] words;
  } rr_cmp_stats_t;

endpackage

// File: rtl/rr_compactor_word_fifo.sv
// Show-ahead word FIFO carrying a last flag; reports occupancy, almost-full and sticky drop.
module rr_compactor_word_fifo #(
  parameter int WIDTH = 512,
  parameter int DEPTH = 16,
  parameter int SLACK = 6
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         push_last,
  input  logic                         ready,
  output logic                         valid,
  output logic [WIDTH-1:0]             data,
  output logic                         last,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         almful,
  output logic                         overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH:0]     mem_r [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [CNT_W-1:0]   count_r;
  logic [CNT_W-1:0]   count_nxt_s;
  logic               almful_r;
  logic               overflow_r;
  logic               pop_s;
  logic               full_s;
  logic               wr_s;
  logic               drop_s;

  // A full FIFO still accepts a write when the head leaves in the same cycle
  always_comb begin
    pop_s  = (count_r != {CNT_W{1'b0}}) && ready;
    full_s = (count_r == CNT_W'(DEPTH));
    wr_s   = push && (!full_s || pop_s);
    drop_s = push && full_s && !pop_s;
    if (wr_s && !pop_s) begin
      count_nxt_s = count_r + CNT_W'(1);
    end else if (pop_s && !wr_s) begin
      count_nxt_s = count_r - CNT_W'(1);
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Storage array
  always_ff @(posedge clk) begin
    if (wr_s) begin
      mem_r[wr_ptr_r] <= {push_last, push_data};
    end
  end

  // Pointers, occupancy and status flags
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_r   <= {PTR_W{1'b0}};
      rd_ptr_r   <= {PTR_W{1'b0}};
      count_r    <= {CNT_W{1'b0}};
      almful_r   <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      if (wr_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (pop_s) rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      count_r    <= count_nxt_s;
      almful_r   <= (count_nxt_s >= CNT_W'(DEPTH - SLACK));
      overflow_r <= overflow_r | drop_s;
    end
  end

  assign valid    = (count_r != {CNT_W{1'b0}});
  assign data     = mem_r[rd_ptr_r][WIDTH-1:0];
  assign last     = mem_r[rd_ptr_r][WIDTH];
  assign count    = count_r;
  assign almful   = almful_r;
  assign overflow = overflow_r;

endmodule

// File: rtl/rr_plogb_compactor.sv
// Packs variable-length logb records into OUT_WIDTH trace words with flush/drain control.
// Optional statistics outputs are enabled by defining RR_COMPACTOR_STATS_EN.
module rr_plogb_compactor
  import rr_compactor_pkg::*;
#(
  parameter int IN_WIDTH     = 512,
  parameter int OUT_WIDTH    = 512,
  parameter int FIFO_DEPTH   = 16,
  parameter int ALMFUL_SLACK = 6
) (
  input  logic                                clk,
  input  logic                                rstn,
  input  logic                                in_any_valid,
  input  logic [IN_WIDTH-1:0]                 in_data,
  input  logic [LEN_WIDTH(IN_WIDTH)-1:0]      in_len,
  output logic                                in_almful,
  input  logic                                flush,
  output logic                                flush_done,
  output logic                                out_valid,
  output logic [OUT_WIDTH-1:0]                out_data,
  output logic                                out_last,
  input  logic                                out_ready,
  output logic                                overflow
`ifdef RR_COMPACTOR_STATS_EN
  ,
  output logic [63:0]                         stat_bits,
  output logic [31:0]                         stat_words,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]     stat_max_occ
`endif
);

  localparam int FW    = FILL_WIDTH(OUT_WIDTH);
  localparam int LW    = LEN_WIDTH(IN_WIDTH);
  localparam int AW    = 2 * OUT_WIDTH;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  if (IN_WIDTH > OUT_WIDTH) begin : g_bad_width
    $error("rr_plogb_compactor: IN_WIDTH must not exceed OUT_WIDTH");
  end

  logic [AW-1:0]        acc_r, acc_nxt_s, acc_keep_s, acc_ins_s;
  logic [FW-1:0]        fill_r, fill_nxt_s, sum_s;
  logic [IN_WIDTH-1:0]  len_mask_s;
  rr_cmp_state_t        state_r, state_nxt_s;
  logic                 append_s, push_s, push_last_s;
  logic [OUT_WIDTH-1:0] push_data_s;
  logic                 flush_done_r, flush_done_nxt_s;
  logic [CNT_W-1:0]     fifo_count_s;

  // Append masked record at fill, cut a full word, or emit the padded flush word
  always_comb begin
    append_s    = in_any_valid && (in_len != {LW{1'b0}});
    len_mask_s  = ~({IN_WIDTH{1'b1}} << in_len);
    acc_keep_s  = acc_r & ~({AW{1'b1}} << fill_r);
    acc_ins_s   = acc_keep_s | ({{(AW-IN_WIDTH){1'b0}}, in_data & len_mask_s} << fill_r);
    sum_s       = fill_r + FW'(in_len);
    acc_nxt_s   = acc_r;
    fill_nxt_s  = fill_r;
    push_s      = 1'b0;
    push_last_s = 1'b0;
    push_data_s = acc_ins_s[OUT_WIDTH-1:0];
    if (append_s) begin
      if (sum_s >= FW'(OUT_WIDTH)) begin
        push_s     = 1'b1;
        acc_nxt_s  = acc_ins_s >> OUT_WIDTH;
        fill_nxt_s = sum_s - FW'(OUT_WIDTH);
      end else begin
        acc_nxt_s  = acc_ins_s;
        fill_nxt_s = sum_s;
      end
    end else if (state_r == ST_FLUSH_PAD) begin
      if (fill_r != {FW{1'b0}}) begin
        push_s      = 1'b1;
        push_last_s = 1'b1;
        push_data_s = acc_keep_s[OUT_WIDTH-1:0];
      end else begin
        push_s      = 1'b0;
      end
      acc_nxt_s  = {AW{1'b0}};
      fill_nxt_s = {FW{1'b0}};
    end else begin
      acc_nxt_s  = acc_r;
    end
  end

  // Flush sequencing; the drain completes only once nothing is queued or arriving
  always_comb begin
    state_nxt_s      = state_r;
    flush_done_nxt_s = 1'b0;
    case (state_r)
      ST_RUN: begin
        if (flush) state_nxt_s = ST_FLUSH_PAD;
        else       state_nxt_s = ST_RUN;
      end
      ST_FLUSH_PAD: begin
        if (!append_s) state_nxt_s = ST_FLUSH_DRAIN;
        else           state_nxt_s = ST_FLUSH_PAD;
      end
      ST_FLUSH_DRAIN: begin
        if ((fifo_count_s == {CNT_W{1'b0}}) && !push_s) begin
          state_nxt_s      = ST_RUN;
          flush_done_nxt_s = 1'b1;
        end else begin
          state_nxt_s      = ST_FLUSH_DRAIN;
        end
      end
      default: state_nxt_s = ST_RUN;
    endcase
  end

  // Accumulator, fill level and FSM state
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc_r        <= {AW{1'b0}};
      fill_r       <= {FW{1'b0}};
      state_r      <= ST_RUN;
      flush_done_r <= 1'b0;
    end else begin
      acc_r        <= acc_nxt_s;
      fill_r       <= fill_nxt_s;
      state_r      <= state_nxt_s;
      flush_done_r <= flush_done_nxt_s;
    end
  end

  rr_compactor_word_fifo #(
    .WIDTH (OUT_WIDTH),
    .DEPTH (FIFO_DEPTH),
    .SLACK (ALMFUL_SLACK)
  ) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (push_s),
    .push_data (push_data_s),
    .push_last (push_last_s),
    .ready     (out_ready),
    .valid     (out_valid),
    .data      (out_data),
    .last      (out_last),
    .count     (fifo_count_s),
    .almful    (in_almful),
    .overflow  (overflow)
  );

  assign flush_done = flush_done_r;

`ifdef RR_COMPACTOR_STATS_EN
  rr_cmp_stats_t    stats_r;
  logic [CNT_W-1:0] max_occ_r;
  logic [64:0]      bits_sum_s;

  // Saturating sum of appended bits
  always_comb begin
    bits_sum_s = {1'b0, stats_r.bits} + 65'(in_len);
  end

  // Saturating statistics counters and FIFO high-water mark
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stats_r   <= '{bits: 64'd0, words: 32'd0};
      max_occ_r <= {CNT_W{1'b0}};
    end else begin
      if (append_s) stats_r.bits <= bits_sum_s[64] ? 64'hFFFF_FFFF_FFFF_FFFF : bits_sum_s[63:0];
      if (push_s && (stats_r.words != 32'hFFFF_FFFF)) stats_r.words <= stats_r.words + 32'd1;
      if (fifo_count_s > max_occ_r) max_occ_r <= fifo_count_s;
    end
  end

  assign stat_bits    = stats_r.bits;
  assign stat_words   = stats_r.words;
  assign stat_max_occ = max_occ_r;
`endif

endmodule

// File: tb/tb_rr_plogb_compactor.sv
// Self-checking bench for rr_plogb_compactor: directed vector table, corner sequences and a random stream.
module tb_rr_plogb_compactor;

  localparam int W     = 512;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rstn;
  logic          in_any_valid;
  logic [W-1:0]  in_data;
  logic [9:0]    in_len;
  logic          in_almful;
  logic          flush;
  logic          flush_done;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic          out_last;
  logic          out_ready;
  logic          overflow;
`ifdef RR_COMPACTOR_STATS_EN
  logic [63:0]   stat_bits;
  logic [31:0]   stat_words;
  logic [4:0]    stat_max_occ;
`endif

  rr_plogb_compactor dut (
    .clk          (clk),
    .rstn         (rstn),
    .in_any_valid (in_any_valid),
    .in_data      (in_data),
    .in_len       (in_len),
    .in_almful    (in_almful),
    .flush        (flush),
    .flush_done   (flush_done),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_last     (out_last),
    .out_ready    (out_ready),
    .overflow     (overflow)
`ifdef RR_COMPACTOR_STATS_EN
    ,
    .stat_bits    (stat_bits),
    .stat_words   (stat_words),
    .stat_max_occ (stat_max_occ)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_drops  = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: the stream is a plain queue of bits, cut into words as they accumulate.
  typedef struct { logic [W-1:0] w; bit last; } exp_t;
  bit   mbits[$];
  exp_t exp_q[$];

  function automatic void model_push(input logic [W-1:0] w, input bit last);
    exp_t e;
    e.w = w;
    e.last = last;
    if (exp_q.size() >= DEPTH && !out_ready) n_drops++;
    else exp_q.push_back(e);
  endfunction

  function automatic void model_append(input logic [W-1:0] d, input int len);
    logic [W-1:0] w;
    for (int i = 0; i < len; i++) mbits.push_back(d[i]);
    if (mbits.size() >= W) begin
      for (int i = 0; i < W; i++) w[i] = mbits.pop_front();
      model_push(w, 1'b0);
    end
  endfunction

  function automatic void model_flush();
    logic [W-1:0] w;
    w = '0;
    if (mbits.size() > 0) begin
      for (int i = 0; i < mbits.size(); i++) w[i] = mbits[i];
      mbits.delete();
      model_push(w, 1'b1);
    end
  endfunction

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] r;
    for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  // Scoreboard: every word the consumer takes must match the model, in order.
  always @(negedge clk) begin
    if (rstn && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_extra: got word %h expected none", out_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_data", out_data, e.w);
        check("sb_last", out_last, e.last);
      end
    end
  end

  task automatic drive(input bit v, input logic [W-1:0] d, input int len);
    in_any_valid = v;
    in_data      = d;
    in_len       = len[9:0];
    if (v && len != 0) model_append(d, len);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, 0);
  endtask

  typedef struct {
    logic [W-1:0] d;
    int           len;
    bit           exp_push;
    logic [W-1:0] exp_word;
    int           exp_fill;
  } vec_t;

  vec_t         vt[7];
  logic [W-1:0] p1, p2, exp_pad, r;
  int           pulses;

  initial begin
    rstn = 1'b0; in_any_valid = 1'b0; in_data = '0; in_len = '0;
    flush = 1'b0; out_ready = 1'b0;

    p1 = {64{8'h3C}};
    p2 = {64{8'h96}};
    vt[0] = '{{{96{4'hF}}, {32{4'hA}}}, 128, 1'b0, '0, 128};
    vt[1] = '{{{96{4'hF}}, {32{4'hB}}}, 128, 1'b0, '0, 256};
    vt[2] = '{{{96{4'hF}}, {32{4'hC}}}, 128, 1'b0, '0, 384};
    vt[3] = '{{{96{4'hF}}, {32{4'hD}}}, 128, 1'b1,
              {{32{4'hD}}, {32{4'hC}}, {32{4'hB}}, {32{4'hA}}}, 0};
    vt[4] = '{p1, 300, 1'b0, '0, 300};
    vt[5] = '{p2, 300, 1'b1, {p2[211:0], p1[299:0]}, 88};
    vt[6] = '{{W{1'b1}}, 0, 1'b0, '0, 88};

    // Reset state
    #12;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_almful", in_almful, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_flush_done", flush_done, 1'b0);
    check("rst_fill", dut.fill_r, 0);
    @(posedge clk); #1;
    rstn = 1'b1;
    idle(1);

    // Vector table: packing, masking of bits above len, zero-length records
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, vt[i].d, vt[i].len);
      check($sformatf("vec%0d_fill", i), dut.fill_r, vt[i].exp_fill);
      check($sformatf("vec%0d_valid", i), out_valid, vt[i].exp_push);
      if (vt[i].exp_push) begin
        check($sformatf("vec%0d_data", i), out_data, vt[i].exp_word);
        check($sformatf("vec%0d_last", i), out_last, 1'b0);
      end
    end
    idle(10);
    check("idle_fill", dut.fill_r, 88);
    check("idle_no_push", out_valid, 1'b0);

    // Flush with 88 bits pending: padded last word, then one flush_done pulse
    out_ready = 1'b0;
    flush = 1'b1;
    model_flush();
    idle(1);
    flush = 1'b0;
    idle(1);
    exp_pad = '0;
    exp_pad[87:0] = p2[299:212];
    check("flush_valid", out_valid, 1'b1);
    check("flush_data", out_data, exp_pad);
    check("flush_last", out_last, 1'b1);
    check("flush_done_early", flush_done, 1'b0);
    check("flush_fill", dut.fill_r, 0);
    out_ready = 1'b1;
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      idle(1);
      if (flush_done) pulses++;
    end
    check("flush_done_pulses", pulses, 1);

    // Back-pressure: almost-full threshold, drop of the 17th word, sticky overflow
    out_ready = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      drive(1'b1, rand_word(), 512);
      check($sformatf("almful_k%0d", k), in_almful, (k >= 10));
      if (k == 16) check("overflow_at16", overflow, 1'b0);
    end
    check("overflow_at17", overflow, 1'b1);
    idle(3);
    check("overflow_sticky", overflow, 1'b1);
    out_ready = 1'b1;
    idle(20);
    check("drain_empty", out_valid, 1'b0);
    check("drain_almful", in_almful, 1'b0);
    check("overflow_sticky_drained", overflow, 1'b1);

    // Asynchronous reset mid-operation
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) drive(1'b1, rand_word(), 512);
    drive(1'b1, rand_word(), 300);
    idle(1);
    check("pre_rst_fill", dut.fill_r, 300);
    check("pre_rst_count", dut.fifo_count_s, 3);
    #3;
    rstn = 1'b0;
    mbits.delete();
    exp_q.delete();
    n_drops = 0;
    #2;
    check("async_rst_valid", out_valid, 1'b0);
    check("async_rst_fill", dut.fill_r, 0);
    check("async_rst_almful", in_almful, 1'b0);
    check("async_rst_overflow", overflow, 1'b0);
    @(posedge clk); #1;
    rstn = 1'b1;
    r = rand_word();
    drive(1'b1, r, 512);
    check("post_rst_valid", out_valid, 1'b1);
    check("post_rst_data", out_data, r);
    check("post_rst_last", out_last, 1'b0);
    out_ready = 1'b1;
    idle(2);

    // Random stream against the bit-queue model
    for (int c = 0; c < 400; c++) begin
      out_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 1) == 1) drive(1'b1, rand_word(), $urandom_range(0, 512));
      else drive(1'b0, rand_word(), $urandom_range(0, 512));
    end
    out_ready = 1'b1;
    flush = 1'b1;
    model_flush();
    idle(1);
    flush = 1'b0;
    pulses = 0;
    for (int i = 0; i < 60; i++) begin
      idle(1);
      if (flush_done) pulses++;
    end
    check("rand_flush_pulses", pulses, 1);
    check("rand_empty", out_valid, 1'b0);
    check("rand_overflow", overflow, (n_drops > 0));
    check("rand_model_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
